// File: rtl/core_bus_arbiter_pkg.sv
// Shared core microarchitecture types, plus the arbiter state encoding and
// the beat-address helper used by the external memory port arbiter.
package core_bus_arbiter_pkg;

    typedef logic [31:0]  word;
    typedef logic [127:0] qword;
    typedef logic [29:0]  ptr;
    typedef logic [27:0]  qptr;

    // Number of 32-bit beats that make up one 128-bit instruction line.
    localparam int unsigned INSN_BEATS = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_INSN = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    // Word address of beat 'beat' within the qword line at 'line_addr'.
    function automatic ptr beat_addr(input qptr line_addr, input logic [1:0] beat);
        return {line_addr, beat};
    endfunction

endpackage

// File: rtl/core_arb_pick.sv
// Combinational grant selector: picks at most one of the two pending
// requesters, using fixed data precedence or round-robin on last_grant.
module core_arb_pick
    import core_bus_arbiter_pkg::*;
#(
    parameter bit DATA_PRIORITY = 1'b1
) (
    input  logic insn_pend_i,
    input  logic data_pend_i,
    input  logic last_grant_data_i,
    output logic grant_insn_o,
    output logic grant_data_o
);

    // Grant selection; a tie goes to data or to whoever was not granted last.
    always_comb begin
        grant_insn_o = 1'b0;
        grant_data_o = 1'b0;
        if (insn_pend_i && data_pend_i) begin
            if (DATA_PRIORITY) begin
                grant_data_o = 1'b1;
            end else if (last_grant_data_i) begin
                grant_insn_o = 1'b1;
            end else begin
                grant_data_o = 1'b1;
            end
        end else if (data_pend_i) begin
            grant_data_o = 1'b1;
        end else if (insn_pend_i) begin
            grant_insn_o = 1'b1;
        end else begin
            grant_insn_o = 1'b0;
            grant_data_o = 1'b0;
        end
    end

endmodule

// File: rtl/core_bus_arbiter.sv
// Shares the single 32-bit memory port between instruction line fills
// (four word beats reassembled into a qword) and load/store word accesses.
// Grant and beat issue are registered, so a start seen while idle puts
// bus_start on the wire in the following cycle.
module core_bus_arbiter
    import core_bus_arbiter_pkg::*;
#(
    parameter bit DATA_PRIORITY = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         insn_start,
    input  logic [27:0]  insn_addr,
    output logic         insn_ready,
    output logic [127:0] insn_data_rd,
    input  logic         data_start,
    input  logic         data_write,
    input  logic [29:0]  data_addr,
    input  logic [31:0]  data_data_wr,
    input  logic [3:0]   data_data_be,
    output logic         data_ready,
    output logic [31:0]  data_data_rd,
    output logic         bus_start,
    output logic         bus_write,
    output logic [29:0]  bus_addr,
    output logic [31:0]  bus_data_wr,
    output logic [3:0]   bus_data_be,
    input  logic         bus_ready,
    input  logic [31:0]  bus_data_rd
);

    localparam logic [1:0] LAST_BEAT = 2'(INSN_BEATS - 1);

    arb_state_e  state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    logic [95:0] line_q, line_d;
    logic        last_grant_q, last_grant_d;
    logic        outstanding_q, outstanding_d;

    logic        insn_pend_q, insn_pend_d;
    qptr         insn_addr_q, insn_addr_d;
    logic        data_pend_q, data_pend_d;
    logic        data_write_q, data_write_d;
    ptr          data_addr_q, data_addr_d;
    word         data_wdata_q, data_wdata_d;
    logic [3:0]  data_be_q, data_be_d;

    logic        bus_start_q, bus_start_d;
    logic        bus_write_q, bus_write_d;
    ptr          bus_addr_q, bus_addr_d;
    word         bus_data_wr_q, bus_data_wr_d;
    logic [3:0]  bus_data_be_q, bus_data_be_d;
    logic        insn_ready_q, insn_ready_d;
    qword        insn_data_rd_q, insn_data_rd_d;
    logic        data_ready_q, data_ready_d;
    word         data_data_rd_q, data_data_rd_d;

    logic        insn_accept_s, data_accept_s;
    logic        insn_pend_s, data_pend_s;
    logic        grant_insn_s, grant_data_s;
    logic        bus_ready_s;

    // A start is accepted only when that requester is neither pending nor in
    // service (its pend flag covers both); accepted fields are captured here,
    // and the _d copies double as the "effective" request seen by arbitration.
    always_comb begin
        insn_accept_s = insn_start & ~insn_pend_q;
        data_accept_s = data_start & ~data_pend_q;
        insn_pend_s   = insn_pend_q | insn_accept_s;
        data_pend_s   = data_pend_q | data_accept_s;
        if (insn_accept_s) begin
            insn_addr_d = insn_addr;
        end else begin
            insn_addr_d = insn_addr_q;
        end
        if (data_accept_s) begin
            data_write_d = data_write;
            data_addr_d  = data_addr;
            data_wdata_d = data_data_wr;
            data_be_d    = data_data_be;
        end else begin
            data_write_d = data_write_q;
            data_addr_d  = data_addr_q;
            data_wdata_d = data_wdata_q;
            data_be_d    = data_be_q;
        end
    end

    core_arb_pick #(
        .DATA_PRIORITY(DATA_PRIORITY)
    ) u_pick (
        .insn_pend_i      (insn_pend_s),
        .data_pend_i      (data_pend_s),
        .last_grant_data_i(last_grant_q),
        .grant_insn_o     (grant_insn_s),
        .grant_data_o     (grant_data_s)
    );

    // A bus_ready with no beat in flight is stray and must not advance anything.
    assign bus_ready_s = bus_ready & outstanding_q;

    // Arbitration, beat sequencing, line assembly and ready-pulse generation.
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        line_d         = line_q;
        last_grant_d   = last_grant_q;
        outstanding_d  = outstanding_q;
        insn_pend_d    = insn_pend_s;
        data_pend_d    = data_pend_s;
        bus_start_d    = 1'b0;
        bus_write_d    = bus_write_q;
        bus_addr_d     = bus_addr_q;
        bus_data_wr_d  = bus_data_wr_q;
        bus_data_be_d  = bus_data_be_q;
        insn_ready_d   = 1'b0;
        insn_data_rd_d = insn_data_rd_q;
        data_ready_d   = 1'b0;
        data_data_rd_d = data_data_rd_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_data_s) begin
                    state_d       = ARB_DATA;
                    last_grant_d  = 1'b1;
                    outstanding_d = 1'b1;
                    bus_start_d   = 1'b1;
                    bus_write_d   = data_write_d;
                    bus_addr_d    = data_addr_d;
                    bus_data_wr_d = data_wdata_d;
                    bus_data_be_d = data_be_d;
                end else if (grant_insn_s) begin
                    state_d       = ARB_INSN;
                    last_grant_d  = 1'b0;
                    outstanding_d = 1'b1;
                    beat_d        = 2'd0;
                    bus_start_d   = 1'b1;
                    bus_write_d   = 1'b0;
                    bus_addr_d    = beat_addr(insn_addr_d, 2'd0);
                    bus_data_wr_d = 32'h0000_0000;
                    bus_data_be_d = 4'hF;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_INSN: begin
                if (bus_ready_s && (beat_q == LAST_BEAT)) begin
                    insn_ready_d   = 1'b1;
                    insn_data_rd_d = {bus_data_rd, line_q};
                    insn_pend_d    = 1'b0;
                    outstanding_d  = 1'b0;
                    beat_d         = 2'd0;
                    state_d        = ARB_IDLE;
                end else if (bus_ready_s) begin
                    case (beat_q)
                        2'd0:    line_d[31:0]  = bus_data_rd;
                        2'd1:    line_d[63:32] = bus_data_rd;
                        2'd2:    line_d[95:64] = bus_data_rd;
                        default: line_d        = line_q;
                    endcase
                    beat_d        = beat_q + 2'd1;
                    outstanding_d = 1'b1;
                    bus_start_d   = 1'b1;
                    bus_addr_d    = beat_addr(insn_addr_q, beat_q + 2'd1);
                end else begin
                    state_d = ARB_INSN;
                end
            end
            ARB_DATA: begin
                if (bus_ready_s) begin
                    data_ready_d   = 1'b1;
                    data_data_rd_d = bus_data_rd;
                    data_pend_d    = 1'b0;
                    outstanding_d  = 1'b0;
                    state_d        = ARB_IDLE;
                end else begin
                    state_d = ARB_DATA;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and output registers; a low rst_n abandons any transfer silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ARB_IDLE;
            beat_q         <= 2'd0;
            line_q         <= 96'h0;
            last_grant_q   <= 1'b1;
            outstanding_q  <= 1'b0;
            insn_pend_q    <= 1'b0;
            insn_addr_q    <= 28'h0;
            data_pend_q    <= 1'b0;
            data_write_q   <= 1'b0;
            data_addr_q    <= 30'h0;
            data_wdata_q   <= 32'h0;
            data_be_q      <= 4'h0;
            bus_start_q    <= 1'b0;
            bus_write_q    <= 1'b0;
            bus_addr_q     <= 30'h0;
            bus_data_wr_q  <= 32'h0;
            bus_data_be_q  <= 4'h0;
            insn_ready_q   <= 1'b0;
            insn_data_rd_q <= 128'h0;
            data_ready_q   <= 1'b0;
            data_data_rd_q <= 32'h0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            line_q         <= line_d;
            last_grant_q   <= last_grant_d;
            outstanding_q  <= outstanding_d;
            insn_pend_q    <= insn_pend_d;
            insn_addr_q    <= insn_addr_d;
            data_pend_q    <= data_pend_d;
            data_write_q   <= data_write_d;
            data_addr_q    <= data_addr_d;
            data_wdata_q   <= data_wdata_d;
            data_be_q      <= data_be_d;
            bus_start_q    <= bus_start_d;
            bus_write_q    <= bus_write_d;
            bus_addr_q     <= bus_addr_d;
            bus_data_wr_q  <= bus_data_wr_d;
            bus_data_be_q  <= bus_data_be_d;
            insn_ready_q   <= insn_ready_d;
            insn_data_rd_q <= insn_data_rd_d;
            data_ready_q   <= data_ready_d;
            data_data_rd_q <= data_data_rd_d;
        end
    end

    assign bus_start    = bus_start_q;
    assign bus_write    = bus_write_q;
    assign bus_addr     = bus_addr_q;
    assign bus_data_wr  = bus_data_wr_q;
    assign bus_data_be  = bus_data_be_q;
    assign insn_ready   = insn_ready_q;
    assign insn_data_rd = insn_data_rd_q;
    assign data_ready   = data_ready_q;
    assign data_data_rd = data_data_rd_q;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Bench for core_bus_arbiter: a cycle-by-cycle vector table against a
// data-priority instance, then a round-robin sequence on a second instance.
module tb_core_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         insn_start, data_start, data_write, bus_ready;
    logic [27:0]  insn_addr;
    logic [29:0]  data_addr;
    logic [31:0]  data_data_wr, bus_data_rd;
    logic [3:0]   data_data_be;
    logic         insn_ready, data_ready, bus_start, bus_write;
    logic [127:0] insn_data_rd;
    logic [31:0]  data_data_rd, bus_data_wr;
    logic [29:0]  bus_addr;
    logic [3:0]   bus_data_be;

    logic         insn_start2, data_start2, bus_ready2;
    logic [31:0]  bus_data_rd2;
    logic         insn_ready2, data_ready2, bus_start2, bus_write2;
    logic [127:0] insn_data_rd2;
    logic [31:0]  data_data_rd2, bus_data_wr2;
    logic [29:0]  bus_addr2;
    logic [3:0]   bus_data_be2;

    core_bus_arbiter #(.DATA_PRIORITY(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .insn_start(insn_start), .insn_addr(insn_addr),
        .insn_ready(insn_ready), .insn_data_rd(insn_data_rd),
        .data_start(data_start), .data_write(data_write), .data_addr(data_addr),
        .data_data_wr(data_data_wr), .data_data_be(data_data_be),
        .data_ready(data_ready), .data_data_rd(data_data_rd),
        .bus_start(bus_start), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_data_wr(bus_data_wr), .bus_data_be(bus_data_be),
        .bus_ready(bus_ready), .bus_data_rd(bus_data_rd)
    );

    core_bus_arbiter #(.DATA_PRIORITY(1'b0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .insn_start(insn_start2), .insn_addr(insn_addr),
        .insn_ready(insn_ready2), .insn_data_rd(insn_data_rd2),
        .data_start(data_start2), .data_write(data_write), .data_addr(data_addr),
        .data_data_wr(data_data_wr), .data_data_be(data_data_be),
        .data_ready(data_ready2), .data_data_rd(data_data_rd2),
        .bus_start(bus_start2), .bus_write(bus_write2), .bus_addr(bus_addr2),
        .bus_data_wr(bus_data_wr2), .bus_data_be(bus_data_be2),
        .bus_ready(bus_ready2), .bus_data_rd(bus_data_rd2)
    );

    typedef struct {
        logic         rst, is;
        logic [27:0]  ia;
        logic         ds, dw;
        logic [29:0]  da;
        logic [31:0]  dwd;
        logic [3:0]   dbe;
        logic         br;
        logic [31:0]  brd;
        logic         bs, bw;
        logic [29:0]  ba;
        logic [3:0]   bbe;
        logic [31:0]  bwd;
        logic         ir, dr;
        logic [31:0]  drd;
        logic [127:0] ird;
    } vec_t;

    function automatic vec_t V(
        input logic rst, is, input logic [27:0] ia, input logic ds, dw,
        input logic [29:0] da, input logic [31:0] dwd, input logic [3:0] dbe,
        input logic br, input logic [31:0] brd,
        input logic bs, bw, input logic [29:0] ba, input logic [3:0] bbe,
        input logic [31:0] bwd, input logic ir, dr, input logic [31:0] drd,
        input logic [127:0] ird);
        vec_t v;
        v.rst = rst; v.is = is; v.ia = ia; v.ds = ds; v.dw = dw; v.da = da;
        v.dwd = dwd; v.dbe = dbe; v.br = br; v.brd = brd;
        v.bs = bs; v.bw = bw; v.ba = ba; v.bbe = bbe; v.bwd = bwd;
        v.ir = ir; v.dr = dr; v.drd = drd; v.ird = ird;
        return v;
    endfunction

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic bad;

    // round-robin section bookkeeping
    logic [5:0] ev;
    int         n_ev, i_req, d_req;
    logic       br_pend;

    initial begin
        rst_n = 1'b0; insn_start = 1'b0; data_start = 1'b0; data_write = 1'b0;
        insn_addr = 28'h0; data_addr = 30'h0; data_data_wr = 32'h0; data_data_be = 4'h0;
        bus_ready = 1'b0; bus_data_rd = 32'h0;
        insn_start2 = 1'b0; data_start2 = 1'b0; bus_ready2 = 1'b0; bus_data_rd2 = 32'h0;

        // inputs: rst is ia ds dw da dwd dbe br brd | expected: bs bw ba bbe bwd ir dr drd ird
        // reset state, then a lone zero-wait load at 30'h100
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b0,1'b0,30'h0,4'h0,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b1,1'b0,30'h100,32'h0,4'hF,1'b0,32'h0, 1'b0,1'b0,30'h0,4'h0,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b1,1'b0,30'h100,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b1,32'hDEADBEEF, 1'b0,1'b0,30'h100,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b0,1'b0,30'h100,4'hF,32'h0,1'b0,1'b1,32'hDEADBEEF,128'h0));
        // lone line fill at 28'h40, beats 0..3
        tbl.push_back(V(1'b1,1'b1,28'h40,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0, 1'b0,1'b0,30'h100,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b1,1'b0,30'h100,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b1,32'h0,  1'b0,1'b0,30'h100,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b1,1'b0,30'h101,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b1,32'h1,  1'b0,1'b0,30'h101,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b1,1'b0,30'h102,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b1,32'h2,  1'b0,1'b0,30'h102,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b1,1'b0,30'h103,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b1,32'h3,  1'b0,1'b0,30'h103,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b0,1'b0,30'h103,4'hF,32'h0,1'b1,1'b0,32'h0,128'h00000003_00000002_00000001_00000000));
        // stray bus_ready while idle is ignored
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b1,32'hFFFFFFFF, 1'b0,1'b0,30'h103,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b0,1'b0,30'h103,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        // simultaneous starts: data first; repeated insn_start while pending ignored
        tbl.push_back(V(1'b1,1'b1,28'h5,1'b1,1'b0,30'h200,32'h0,4'hF,1'b0,32'h0, 1'b0,1'b0,30'h103,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b1,28'h7,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b1,1'b0,30'h200,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b1,32'hCAFEF00D, 1'b0,1'b0,30'h200,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b0,1'b0,30'h200,4'hF,32'h0,1'b0,1'b1,32'hCAFEF00D,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b1,1'b0,30'h014,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b1,32'hA0, 1'b0,1'b0,30'h014,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b1,1'b0,30'h015,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b1,32'hA1, 1'b0,1'b0,30'h015,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b1,1'b0,30'h016,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b1,32'hA2, 1'b0,1'b0,30'h016,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b1,1'b0,30'h017,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b1,32'hA3, 1'b0,1'b0,30'h017,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b0,1'b0,30'h017,4'hF,32'h0,1'b1,1'b0,32'h0,128'h000000A3_000000A2_000000A1_000000A0));
        // store with 3 wait cycles: attributes held, data_ready one cycle after bus_ready
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b1,1'b1,30'h55,32'h1234,4'h3,1'b0,32'h0, 1'b0,1'b0,30'h017,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b1,1'b1,30'h055,4'h3,32'h1234,1'b0,1'b0,32'h0,128'h0));
        for (int w = 0; w < 3; w++)
            tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0, 1'b0,1'b1,30'h055,4'h3,32'h1234,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b1,32'h0,  1'b0,1'b1,30'h055,4'h3,32'h1234,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b0,1'b1,30'h055,4'h3,32'h1234,1'b0,1'b1,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b0,1'b1,30'h055,4'h3,32'h1234,1'b0,1'b0,32'h0,128'h0));
        // fill at 28'h9, reset while beat 2 is outstanding, then a fresh fill
        tbl.push_back(V(1'b1,1'b1,28'h9,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b0,1'b1,30'h055,4'h3,32'h1234,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b1,1'b0,30'h024,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b1,32'h11, 1'b0,1'b0,30'h024,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b1,1'b0,30'h025,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b1,32'h22, 1'b0,1'b0,30'h025,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b0,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b1,1'b0,30'h026,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b1,32'h33, 1'b0,1'b0,30'h0,4'h0,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b1,28'h9,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b0,1'b0,30'h0,4'h0,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b1,1'b0,30'h024,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b1,32'h44, 1'b0,1'b0,30'h024,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b1,1'b0,30'h025,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b1,32'h55, 1'b0,1'b0,30'h025,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b1,1'b0,30'h026,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b1,32'h66, 1'b0,1'b0,30'h026,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b1,1'b0,30'h027,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b1,32'h77, 1'b0,1'b0,30'h027,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b0,1'b0,30'h027,4'hF,32'h0,1'b1,1'b0,32'h0,128'h00000077_00000066_00000055_00000044));
        tbl.push_back(V(1'b1,1'b0,28'h0,1'b0,1'b0,30'h0,32'h0,4'h0,1'b0,32'h0,  1'b0,1'b0,30'h027,4'hF,32'h0,1'b0,1'b0,32'h0,128'h0));

        repeat (2) @(posedge clk);
        @(negedge clk);

        // apply each row on the falling edge and check the outputs of that cycle
        for (int r = 0; r < tbl.size(); r++) begin
            rst_n = tbl[r].rst; insn_start = tbl[r].is; insn_addr = tbl[r].ia;
            data_start = tbl[r].ds; data_write = tbl[r].dw; data_addr = tbl[r].da;
            data_data_wr = tbl[r].dwd; data_data_be = tbl[r].dbe;
            bus_ready = tbl[r].br; bus_data_rd = tbl[r].brd;
            n_vec++;
            bad = (bus_start !== tbl[r].bs) || (bus_write !== tbl[r].bw) ||
                  (bus_addr !== tbl[r].ba) || (bus_data_be !== tbl[r].bbe) ||
                  (bus_data_wr !== tbl[r].bwd) || (insn_ready !== tbl[r].ir) ||
                  (data_ready !== tbl[r].dr) ||
                  (tbl[r].dr && (data_data_rd !== tbl[r].drd)) ||
                  (tbl[r].ir && (insn_data_rd !== tbl[r].ird));
            if (bad) begin
                n_bad++;
                $display("FAIL vec%0d: got bs=%b bw=%b ba=%h be=%h wd=%h ir=%b dr=%b drd=%h ird=%h; need bs=%b bw=%b ba=%h be=%h wd=%h ir=%b dr=%b drd=%h ird=%h",
                         r, bus_start, bus_write, bus_addr, bus_data_be, bus_data_wr, insn_ready, data_ready, data_data_rd, insn_data_rd,
                         tbl[r].bs, tbl[r].bw, tbl[r].ba, tbl[r].bbe, tbl[r].bwd, tbl[r].ir, tbl[r].dr, tbl[r].drd, tbl[r].ird);
            end
            @(posedge clk);
            @(negedge clk);
        end

        // round-robin instance: both requesters re-request in their ready cycle, 3 rounds each
        insn_start = 1'b0; data_start = 1'b0; bus_ready = 1'b0; rst_n = 1'b1;
        insn_addr = 28'h2; data_addr = 30'h3F; data_write = 1'b0;
        data_data_wr = 32'h0; data_data_be = 4'hF;
        insn_start2 = 1'b1; data_start2 = 1'b1;
        i_req = 1; d_req = 1; n_ev = 0; ev = 6'b0; br_pend = 1'b0;
        for (int cyc = 0; cyc < 400 && n_ev < 6; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            insn_start2 = 1'b0;
            data_start2 = 1'b0;
            bus_ready2 = br_pend;
            br_pend = bus_start2;
            bus_data_rd2 = {2'b00, bus_addr2};
            if (insn_ready2 && n_ev < 6) begin
                ev[n_ev] = 1'b0;
                n_ev++;
                n_vec++;
                if (insn_data_rd2 !== 128'h0000000B_0000000A_00000009_00000008) begin
                    n_bad++;
                    $display("FAIL rr_line: got %h need %h", insn_data_rd2, 128'h0000000B_0000000A_00000009_00000008);
                end
                if (i_req < 3) begin
                    insn_start2 = 1'b1;
                    i_req++;
                end
            end
            if (data_ready2 && n_ev < 6) begin
                ev[n_ev] = 1'b1;
                n_ev++;
                n_vec++;
                if (data_data_rd2 !== 32'h0000003F) begin
                    n_bad++;
                    $display("FAIL rr_word: got %h need %h", data_data_rd2, 32'h0000003F);
                end
                if (d_req < 3) begin
                    data_start2 = 1'b1;
                    d_req++;
                end
            end
        end
        n_vec++;
        if (n_ev != 6) begin
            n_bad++;
            $display("FAIL rr_count: got %0d ready pulses need 6 within the cycle budget", n_ev);
        end
        for (int k = 0; k < 6; k++) begin
            if (k < n_ev) begin
                n_vec++;
                if (ev[k] !== (k % 2 == 1)) begin
                    n_bad++;
                    $display("FAIL rr_order%0d: got %s need %s", k, ev[k] ? "data" : "insn", (k % 2 == 1) ? "data" : "insn");
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
